axi_lite_regs: RTL and testbench
================================

AXI_LITE_REGS -- requirements
Module: axi_lite_regs

Interface
REQ-001 Parameter: P_AXI_ADDR_WIDTH, default 13, byte-address width.
REQ-002 Parameter: P_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 Parameter: P_ID_VALUE, default 32'hE7E1_0001, value returned by the ID register.
REQ-004 Port: clk  in  1  single clock; every output is registered to it.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: s_axi_awaddr in P_AXI_ADDR_WIDTH, s_axi_awvalid in 1, s_axi_awready out 1  AXI-Lite write address channel.
REQ-007 Ports: s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1  AXI-Lite write data channel.
REQ-008 Ports: s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1  AXI-Lite write response channel.
REQ-009 Ports: s_axi_araddr in P_AXI_ADDR_WIDTH, s_axi_arvalid in 1, s_axi_arready out 1  AXI-Lite read address channel.
REQ-010 Ports: s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1  AXI-Lite read data channel.
REQ-011 Port: ctrl_o  out  32  CTRL register contents.
REQ-012 Port: status_i  in  32  live status word, sampled on read.
REQ-013 Port: event_i  in  32  per-bit event pulses feeding EVENT.

Function
REQ-014 The map SHALL be decoded on addr[4:2]: 0x00 ID (RO), 0x04 SCRATCH (RW), 0x08 CTRL (RW), 0x0C STATUS (RO), 0x10 EVENT (W1C).
REQ-015 Address bits [1:0] SHALL be ignored; any address >= 0x14 is out of range.
REQ-016 AW and W SHALL be accepted independently, in either order; each is latched, and its ready deasserts until the write completes.
REQ-017 A write SHALL be performed in the cycle after both AW and W are held; bvalid rises that cycle.
REQ-018 Latency: AW and W handshake together at cycle N -> register updated and bvalid=1 at N+1.
REQ-019 Only wstrb-enabled byte lanes SHALL update SCRATCH and CTRL.
REQ-020 Writes to ID or STATUS SHALL be dropped and responded normally.
REQ-021 A 1 written to an enabled EVENT bit SHALL clear that bit.
REQ-022 Each event_i bit SHALL set its EVENT bit; a set SHALL win over a simultaneous clear.
REQ-023 bvalid and bresp SHALL hold until bready; awready and wready reassert the cycle after the B handshake.
REQ-024 At most one write and one read SHALL be outstanding at any time.
REQ-025 arready SHALL be high whenever rvalid is low.
REQ-026 An AR handshake at cycle N SHALL give rvalid=1 with rdata at N+1.
REQ-027 rdata and rresp SHALL stay stable until rready; arready reasserts the cycle after the R handshake.
REQ-028 A read and a write to the same register in the same cycle SHALL return the pre-write value.
REQ-029 Valid accesses SHALL return bresp/rresp = OKAY (2'b00).

Reset
REQ-030 While rst is high, all outputs SHALL be 0: readies, valids, resp, rdata, ctrl_o. SCRATCH, CTRL and EVENT SHALL clear.
REQ-031 awready, wready and arready SHALL assert the first clk edge after rst deasserts.
REQ-032 A reset mid-transaction SHALL discard any latched AW, W or AR with no response issued.

Configuration
REQ-033 Macro AXI_LITE_REGS_ERR_RESP_EN defined: out-of-range accesses SHALL return SLVERR (2'b10), rdata 0, and no register change.
REQ-034 Macro undefined: out-of-range accesses SHALL return OKAY, reads return 0, writes ignored.

Structure
REQ-035 Package axi_lite_pkg SHALL hold the resp constants (OKAY, SLVERR), the register offset constants and the register-index enum typedef.
REQ-036 Sub-module axi_lite_regs_bank SHALL hold the register storage, strobe merge, W1C/event logic and read mux; the top holds the handshake FSMs.

Verification
REQ-037 AW 0x04 and W 0xDEADBEEF with strb 0xF in the same cycle -> bvalid next cycle, bresp 0; read 0x04 -> 0xDEADBEEF.
REQ-038 W (0x0000_00AA, strb 0x1) 3 cycles before AW 0x08 -> ctrl_o[7:0]=0xAA, other bits unchanged, exactly one B.
REQ-039 Pulse event_i[3]; write 0x8 to 0x10 in the same cycle as a second event_i[3] pulse -> EVENT[3] remains 1.
REQ-040 Read 0x00 with rready held low 5 cycles -> rvalid and rdata=0xE7E10001 stable throughout, arready low.
REQ-041 Write 0x40 with the macro defined -> bresp=2'b10; without the macro -> bresp=0; no register changes in either case.
REQ-042 Assert rst between the AW and W handshakes -> no bvalid; after reset, SCRATCH reads 0 and awready is high.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared constants, register-index enum and helpers for the AXI-Lite register block.
package axi_lite_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    localparam logic [31:0] OffsId      = 32'h00;
    localparam logic [31:0] OffsScratch = 32'h04;
    localparam logic [31:0] OffsCtrl    = 32'h08;
    localparam logic [31:0] OffsStatus  = 32'h0C;
    localparam logic [31:0] OffsEvent   = 32'h10;

    typedef enum logic [2:0] {
        RegId      = 3'd0,
        RegScratch = 3'd1,
        RegCtrl    = 3'd2,
        RegStatus  = 3'd3,
        RegEvent   = 3'd4,
        RegNone    = 3'd7
    } reg_idx_e;

    // Takes the word address so that byte-offset bits never reach the decode.
    function automatic reg_idx_e addr_to_idx(logic [29:0] word_addr);
        logic [31:0] byte_addr;
        reg_idx_e    idx;
        byte_addr = {word_addr, 2'b00};
        case (byte_addr)
            OffsId:      idx = RegId;
            OffsScratch: idx = RegScratch;
            OffsCtrl:    idx = RegCtrl;
            OffsStatus:  idx = RegStatus;
            OffsEvent:   idx = RegEvent;
            default:     idx = RegNone;
        endcase
        return idx;
    endfunction

    function automatic logic [31:0] strb_mask(logic [3:0] strb);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_lite_regs_if.sv
// AXI-Lite slave bus bundle for axi_lite_regs; master drives requests, slave drives responses.
interface axi_lite_regs_if #(
    parameter int unsigned P_AXI_ADDR_WIDTH = 13
) ();

    logic [P_AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                        s_axi_awvalid;
    logic                        s_axi_awready;
    logic [31:0]                 s_axi_wdata;
    logic [3:0]                  s_axi_wstrb;
    logic                        s_axi_wvalid;
    logic                        s_axi_wready;
    logic [1:0]                  s_axi_bresp;
    logic                        s_axi_bvalid;
    logic                        s_axi_bready;
    logic [P_AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic                        s_axi_arvalid;
    logic                        s_axi_arready;
    logic [31:0]                 s_axi_rdata;
    logic [1:0]                  s_axi_rresp;
    logic                        s_axi_rvalid;
    logic                        s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

endinterface

// File: rtl/axi_lite_regs_bank.sv
// Register storage, byte-strobe merge, W1C event logic and read mux.
// AXI_LITE_REGS_ERR_RESP_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_regs_bank
    import axi_lite_pkg::*;
#(
    parameter int unsigned P_AXI_ADDR_WIDTH = 13,
    parameter logic [31:0] P_ID_VALUE       = 32'hE7E1_0001
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [P_AXI_ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]                 wr_data,
    input  logic [3:0]                  wr_strb,
    output logic [1:0]                  wr_resp,
    input  logic [P_AXI_ADDR_WIDTH-1:0] rd_addr,
    output logic [31:0]                 rd_data,
    output logic [1:0]                  rd_resp,
    output logic [31:0]                 ctrl,
    input  logic [31:0]                 status,
    input  logic [31:0]                 event_in
);

`ifdef AXI_LITE_REGS_ERR_RESP_EN
    localparam logic [1:0] OorResp = RespSlvErr;
`else
    localparam logic [1:0] OorResp = RespOkay;
`endif

    reg_idx_e    wr_idx, rd_idx;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] event_q, event_d;
    logic [31:0] wr_mask, event_clr;

    assign wr_idx  = addr_to_idx(30'(wr_addr >> 2));
    assign rd_idx  = addr_to_idx(30'(rd_addr >> 2));
    assign wr_mask = strb_mask(wr_strb);

    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        event_clr = '0;
        if (wr_en) begin
            case (wr_idx)
                RegScratch: scratch_d = (scratch_q & ~wr_mask) | (wr_data & wr_mask);
                RegCtrl:    ctrl_d    = (ctrl_q & ~wr_mask) | (wr_data & wr_mask);
                RegEvent:   event_clr = wr_data & wr_mask;
                default:    ;
            endcase
        end
        // New events override a clear landing in the same cycle.
        event_d = (event_q & ~event_clr) | event_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
            event_q   <= '0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            event_q   <= event_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_idx)
            RegId:      rd_data = P_ID_VALUE;
            RegScratch: rd_data = scratch_q;
            RegCtrl:    rd_data = ctrl_q;
            RegStatus:  rd_data = status;
            RegEvent:   rd_data = event_q;
            default:    rd_data = '0;
        endcase
    end

    assign wr_resp = (wr_idx == RegNone) ? OorResp : RespOkay;
    assign rd_resp = (rd_idx == RegNone) ? OorResp : RespOkay;
    assign ctrl    = ctrl_q;

endmodule

// File: rtl/axi_lite_regs.sv
// AXI-Lite register block top: write/read handshake FSMs around axi_lite_regs_bank.
// AXI_LITE_REGS_ERR_RESP_EN selects SLVERR for out-of-range accesses (see bank).
module axi_lite_regs
    import axi_lite_pkg::*;
#(
    parameter int unsigned P_AXI_ADDR_WIDTH = 13,
    parameter int unsigned P_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] P_ID_VALUE       = 32'hE7E1_0001
) (
    input  logic                        clk,
    input  logic                        rst,
    axi_lite_regs_if.slave              s_axi,
    output logic [P_AXI_DATA_WIDTH-1:0] ctrl_o,
    input  logic [P_AXI_DATA_WIDTH-1:0] status_i,
    input  logic [P_AXI_DATA_WIDTH-1:0] event_i
);

    typedef enum logic [1:0] {WrIdle, WrGotAw, WrGotW, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdResp} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic                        awready_q, awready_d, wready_q, wready_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic                        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [P_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]                 wdata_q;
    logic [3:0]                  wstrb_q;

    logic                        aw_hs, w_hs, ar_hs;
    logic                        wr_en;
    logic [P_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]                 wr_data, rd_data;
    logic [3:0]                  wr_strb;
    logic [1:0]                  wr_resp, rd_resp;

    assign aw_hs = s_axi.s_axi_awvalid & awready_q;
    assign w_hs  = s_axi.s_axi_wvalid & wready_q;
    assign ar_hs = s_axi.s_axi_arvalid & arready_q;

    // Use the latched half of the write when it arrived earlier, the live bus otherwise.
    assign wr_addr = (wr_state_q == WrGotAw) ? awaddr_q : s_axi.s_axi_awaddr;
    assign wr_data = (wr_state_q == WrGotW) ? wdata_q : s_axi.s_axi_wdata;
    assign wr_strb = (wr_state_q == WrGotW) ? wstrb_q : s_axi.s_axi_wstrb;

    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_en      = 1'b0;
        case (wr_state_q)
            WrIdle: begin
                awready_d = 1'b1;
                wready_d  = 1'b1;
                if (aw_hs && w_hs) begin
                    wr_en = 1'b1;
                end else if (aw_hs) begin
                    wr_state_d = WrGotAw;
                    awready_d  = 1'b0;
                end else if (w_hs) begin
                    wr_state_d = WrGotW;
                    wready_d   = 1'b0;
                end
            end
            WrGotAw: wr_en = w_hs;
            WrGotW:  wr_en = aw_hs;
            WrResp: begin
                if (s_axi.s_axi_bready) begin
                    wr_state_d = WrIdle;
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
        if (wr_en) begin
            wr_state_d = WrResp;
            awready_d  = 1'b0;
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = wr_resp;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RdIdle: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rd_state_d = RdResp;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_data;
                    rresp_d    = rd_resp;
                end
            end
            RdResp: begin
                if (s_axi.s_axi_rready) begin
                    rd_state_d = RdIdle;
                    arready_d  = 1'b1;
                    rvalid_d   = 1'b0;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= WrIdle;
            rd_state_q <= RdIdle;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            if (aw_hs) awaddr_q <= s_axi.s_axi_awaddr;
            if (w_hs) begin
                wdata_q <= s_axi.s_axi_wdata;
                wstrb_q <= s_axi.s_axi_wstrb;
            end
        end
    end

    axi_lite_regs_bank #(
        .P_AXI_ADDR_WIDTH (P_AXI_ADDR_WIDTH),
        .P_ID_VALUE       (P_ID_VALUE)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .wr_resp  (wr_resp),
        .rd_addr  (s_axi.s_axi_araddr),
        .rd_data  (rd_data),
        .rd_resp  (rd_resp),
        .ctrl     (ctrl_o),
        .status   (status_i),
        .event_in (event_i)
    );

    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regs.sv
// Bench for axi_lite_regs: transaction-level register model checked every cycle plus
// directed literal checks. Honours AXI_LITE_REGS_ERR_RESP_EN for out-of-range responses.
module tb_axi_lite_regs;

`ifdef AXI_LITE_REGS_ERR_RESP_EN
    localparam logic [1:0] ExpOorResp = 2'b10;
`else
    localparam logic [1:0] ExpOorResp = 2'b00;
`endif
    localparam logic [31:0] IdValue = 32'hE7E1_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ctrl;
    logic [31:0] status = 32'hA5A5_0F0F;
    logic [31:0] evt = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int b_count = 0;

    axi_lite_regs_if #(.P_AXI_ADDR_WIDTH(13)) bus ();

    axi_lite_regs #(
        .P_AXI_ADDR_WIDTH (13),
        .P_AXI_DATA_WIDTH (32),
        .P_ID_VALUE       (IdValue)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axi    (bus),
        .ctrl_o   (ctrl),
        .status_i (status),
        .event_i  (evt)
    );

    always #5 clk = ~clk;

    // ---------------- transaction-level model of the register block ----------------
    logic        m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
    logic [1:0]  m_bresp = 0, m_rresp = 0;
    logic [31:0] m_rdata = 0, m_scratch = 0, m_ctrl = 0, m_event = 0;
    logic        m_aw_held = 0, m_w_held = 0;
    logic [12:0] m_awaddr = 0;
    logic [31:0] m_wdata = 0;
    logic [3:0]  m_wstrb = 0;

    function automatic logic [31:0] model_read(logic [12:0] a);
        if (a >= 13'h14) return 32'h0;
        case (a[4:2])
            3'd0:    return IdValue;
            3'd1:    return m_scratch;
            3'd2:    return m_ctrl;
            3'd3:    return status;
            default: return m_event;
        endcase
    endfunction

    function automatic logic [1:0] model_resp(logic [12:0] a);
        return (a >= 13'h14) ? ExpOorResp : 2'b00;
    endfunction

    task automatic model_step();
        logic [31:0] mask, clr;
        logic        aw_hs, w_hs, ar_hs;
        if (rst) begin
            {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
            {m_bresp, m_rresp, m_rdata} = '0;
            {m_scratch, m_ctrl, m_event} = '0;
            {m_aw_held, m_w_held} = '0;
            return;
        end
        aw_hs = bus.s_axi_awvalid && m_awready;
        w_hs  = bus.s_axi_wvalid && m_wready;
        ar_hs = bus.s_axi_arvalid && m_arready;
        // Reads see the register contents from before any write at this edge.
        if (m_rvalid) begin
            if (bus.s_axi_rready) m_rvalid = 1'b0;
        end else if (ar_hs) begin
            m_rvalid = 1'b1;
            m_rdata  = model_read(bus.s_axi_araddr);
            m_rresp  = model_resp(bus.s_axi_araddr);
        end
        m_arready = !m_rvalid;
        clr = '0;
        if (m_bvalid) begin
            if (bus.s_axi_bready) m_bvalid = 1'b0;
        end else begin
            if (aw_hs) begin m_aw_held = 1'b1; m_awaddr = bus.s_axi_awaddr; end
            if (w_hs) begin
                m_w_held = 1'b1; m_wdata = bus.s_axi_wdata; m_wstrb = bus.s_axi_wstrb;
            end
            if (m_aw_held && m_w_held) begin
                for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{m_wstrb[i]}};
                if (m_awaddr < 13'h14) begin
                    case (m_awaddr[4:2])
                        3'd1: m_scratch = (m_scratch & ~mask) | (m_wdata & mask);
                        3'd2: m_ctrl    = (m_ctrl & ~mask) | (m_wdata & mask);
                        3'd4: clr       = m_wdata & mask;
                        default: ;
                    endcase
                end
                m_bvalid  = 1'b1;
                m_bresp   = model_resp(m_awaddr);
                m_aw_held = 1'b0;
                m_w_held  = 1'b0;
            end
        end
        m_event   = (m_event & ~clr) | evt;
        m_awready = !m_aw_held && !m_bvalid;
        m_wready  = !m_w_held && !m_bvalid;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Per-cycle compare of every output against the model.
    initial forever begin
        logic [72:0] got, exp;
        @(negedge clk);
        got = {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid,
               bus.s_axi_bvalid ? bus.s_axi_bresp : 2'b00, bus.s_axi_arready, bus.s_axi_rvalid,
               bus.s_axi_rvalid ? bus.s_axi_rdata : 32'h0,
               bus.s_axi_rvalid ? bus.s_axi_rresp : 2'b00, ctrl};
        exp = {m_awready, m_wready, m_bvalid, m_bvalid ? m_bresp : 2'b00, m_arready, m_rvalid,
               m_rvalid ? m_rdata : 32'h0, m_rvalid ? m_rresp : 2'b00, m_ctrl};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got, exp);
        end
    end

    logic b_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.s_axi_bvalid && !b_prev) b_count++;
        b_prev = bus.s_axi_bvalid;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- stimulus tasks (start and end 1 time unit after posedge) ----------
    task automatic do_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_delay, input logic [31:0] ev,
                            output logic [1:0] resp, output int lat);
        logic aw_todo = 1'b1, aw_on = 1'b0, w_pend = 1'b1, aw_go, w_go, got_b = 1'b0;
        bus.s_axi_awaddr = a;
        bus.s_axi_wdata  = d;
        bus.s_axi_wstrb  = s;
        bus.s_axi_wvalid = 1'b1;
        evt  = ev;
        resp = 2'b11;
        lat  = 0;
        for (int c = 0; c < 30 && (aw_todo || w_pend); c++) begin
            if (aw_todo && !aw_on && c >= aw_delay) begin
                bus.s_axi_awvalid = 1'b1;
                aw_on = 1'b1;
            end
            @(negedge clk);
            aw_go = aw_on && bus.s_axi_awready;
            w_go  = w_pend && bus.s_axi_wready;
            @(posedge clk); #1;
            evt = '0;
            if (aw_go) begin bus.s_axi_awvalid = 1'b0; aw_todo = 1'b0; aw_on = 1'b0; end
            if (w_go) begin bus.s_axi_wvalid = 1'b0; w_pend = 1'b0; end
        end
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        check("write_handshake_timeout", {62'h0, aw_todo, w_pend}, 64'h0);
        for (int c = 0; c < 20 && !got_b; c++) begin
            lat++;
            @(negedge clk);
            if (bus.s_axi_bvalid) begin got_b = 1'b1; resp = bus.s_axi_bresp; end
            @(posedge clk); #1;
        end
        check("write_b_timeout", {63'h0, got_b}, 64'h1);
    endtask

    task automatic do_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic pend = 1'b1, go, got_r = 1'b0;
        bus.s_axi_araddr  = a;
        bus.s_axi_arvalid = 1'b1;
        d    = 32'hX;
        resp = 2'b11;
        for (int c = 0; c < 20 && pend; c++) begin
            @(negedge clk);
            go = bus.s_axi_arready;
            @(posedge clk); #1;
            if (go) begin bus.s_axi_arvalid = 1'b0; pend = 1'b0; end
        end
        bus.s_axi_arvalid = 1'b0;
        for (int c = 0; c < 20 && !got_r; c++) begin
            @(negedge clk);
            if (bus.s_axi_rvalid) begin got_r = 1'b1; d = bus.s_axi_rdata; resp = bus.s_axi_rresp; end
            @(posedge clk); #1;
        end
        check("read_timeout", {62'h0, pend, !got_r}, 64'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat, b0;
        bool_init: begin
            bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0; bus.s_axi_arvalid = 0;
            bus.s_axi_awaddr = '0; bus.s_axi_araddr = '0; bus.s_axi_wdata = '0;
            bus.s_axi_wstrb = '0; bus.s_axi_bready = 1; bus.s_axi_rready = 1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        do_read(13'h04, rd, resp);
        check("scratch_reset", {32'h0, rd}, 64'h0);

        do_write(13'h04, 32'hDEAD_BEEF, 4'hF, 0, '0, resp, lat);
        check("scratch_bresp", {62'h0, resp}, 64'h0);
        check("b_latency", 64'(lat), 64'd1);
        do_read(13'h04, rd, resp);
        check("scratch_read", {30'h0, resp, rd}, 64'hDEAD_BEEF);
        do_read(13'h05, rd, resp);
        check("addr_low_bits_ignored", {32'h0, rd}, 64'hDEAD_BEEF);

        b0 = b_count;
        do_write(13'h08, 32'h0000_00AA, 4'h1, 3, '0, resp, lat);
        idle(4);
        check("w_before_aw_one_b", 64'(b_count - b0), 64'd1);
        check("ctrl_byte0", {32'h0, ctrl}, 64'h0000_00AA);
        do_write(13'h08, 32'h1234_5678, 4'hC, 0, '0, resp, lat);
        check("ctrl_upper_strb", {32'h0, ctrl}, 64'h1234_00AA);

        do_write(13'h00, 32'hFFFF_FFFF, 4'hF, 0, '0, resp, lat);
        check("id_write_bresp", {62'h0, resp}, 64'h0);
        do_read(13'h00, rd, resp);
        check("id_read_only", {32'h0, rd}, {32'h0, IdValue});
        do_read(13'h0C, rd, resp);
        check("status_read", {32'h0, rd}, 64'hA5A5_0F0F);

        evt = 32'h8;
        idle(1);
        evt = '0;
        do_read(13'h10, rd, resp);
        check("event_set", {32'h0, rd}, 64'h8);
        do_write(13'h10, 32'h8, 4'h2, 0, '0, resp, lat);
        do_read(13'h10, rd, resp);
        check("event_clear_strb_masked", {32'h0, rd}, 64'h8);
        do_write(13'h10, 32'h8, 4'hF, 0, 32'h8, resp, lat);
        do_read(13'h10, rd, resp);
        check("event_set_wins", {32'h0, rd}, 64'h8);
        do_write(13'h10, 32'h8, 4'hF, 0, '0, resp, lat);
        do_read(13'h10, rd, resp);
        check("event_w1c", {32'h0, rd}, 64'h0);

        // Read held off by rready for five cycles.
        bus.s_axi_rready  = 1'b0;
        bus.s_axi_araddr  = 13'h00;
        bus.s_axi_arvalid = 1'b1;
        idle(1);
        bus.s_axi_arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("read_hold", {30'h0, bus.s_axi_rvalid, bus.s_axi_rdata, bus.s_axi_arready},
                  {30'h0, 1'b1, IdValue, 1'b0});
            @(posedge clk); #1;
        end
        bus.s_axi_rready = 1'b1;
        idle(1);
        @(negedge clk);
        check("arready_after_r", {62'h0, bus.s_axi_arready, bus.s_axi_rvalid}, 64'h2);
        @(posedge clk); #1;

        do_write(13'h40, 32'hFFFF_FFFF, 4'hF, 0, '0, resp, lat);
        check("oor_bresp", {62'h0, resp}, {62'h0, ExpOorResp});
        do_read(13'h14, rd, resp);
        check("oor_read", {30'h0, resp, rd}, {30'h0, ExpOorResp, 32'h0});
        do_read(13'h04, rd, resp);
        check("oor_no_change", {32'h0, rd}, 64'hDEAD_BEEF);

        // Reset between AW and W: the latched AW must be dropped without a response.
        b0 = b_count;
        bus.s_axi_awaddr  = 13'h04;
        bus.s_axi_awvalid = 1'b1;
        idle(1);
        bus.s_axi_awvalid = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        @(negedge clk);
        check("awready_after_reset", {62'h0, bus.s_axi_awready, bus.s_axi_wready}, 64'h3);
        @(posedge clk); #1;
        bus.s_axi_wdata  = 32'h1111_1111;
        do_read(13'h04, rd, resp);
        check("scratch_after_reset", {32'h0, rd}, 64'h0);
        idle(3);
        check("no_b_after_reset", 64'(b_count - b0), 64'd0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
